// File: rtl/tl_xing_pkg.sv
// Shared TileLink-UL channel layouts, opcodes and beat-count helper for the
// two-client bus-crossing arbiter.
package tl_xing_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef logic [6:0] beats_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic        source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [1:0]  source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } tl_a_wide_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic        source;
        logic [1:0]  sink;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } tl_d_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic [1:0]  source;
        logic [1:0]  sink;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } tl_d_wide_t;

    // Bursts longer than 64 beats cannot be tracked, so the count saturates there.
    function automatic beats_t num_beats(input logic [2:0] opcode, input logic [3:0] size,
                                         input logic is_d, input logic [3:0] beat_shift = 4'd3);
        logic burst;
        burst = is_d ? (opcode == ACCESS_ACK_DATA)
                     : (opcode == PUT_FULL || opcode == PUT_PARTIAL);
        if (!burst || size <= beat_shift) return 7'd1;
        if (size - beat_shift >= 4'd6) return 7'd64;
        return 7'd1 << (size - beat_shift);
    endfunction

endpackage

// File: rtl/tl_xing_arbiter_beat_counter.sv
// Beats-remaining tracker for one channel; flags the first and last beat of
// the message currently on the bus.
module tl_beat_counter
    import tl_xing_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   fire_i,
    input  beats_t beats_i,
    output logic   first_o,
    output logic   last_o,
    output logic   busy_o
);

    logic [5:0] left_q, left_d;

    assign busy_o  = (left_q != '0);
    assign first_o = !busy_o;
    assign last_o  = busy_o ? (left_q == 6'd1) : (beats_i == 7'd1);

    always_comb begin
        left_d = left_q;
        if (fire_i) begin
            left_d = busy_o ? left_q - 6'd1 : 6'(beats_i - 7'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) left_q <= '0;
        else       left_q <= left_d;
    end

endmodule

// File: rtl/tl_xing_arbiter.sv
// Two-client TileLink-UL arbiter: round-robin A grant with burst lock, client
// tag in source MSB, D routing by that tag, per-client outstanding limit.
module tl_xing_arbiter
    import tl_xing_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BEAT_BYTES      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in0_a_valid,
    output logic       in0_a_ready,
    input  tl_a_t      in0_a_bits,
    output logic       in0_d_valid,
    input  logic       in0_d_ready,
    output tl_d_t      in0_d_bits,
    input  logic       in1_a_valid,
    output logic       in1_a_ready,
    input  tl_a_t      in1_a_bits,
    output logic       in1_d_valid,
    input  logic       in1_d_ready,
    output tl_d_t      in1_d_bits,
    output logic       out_a_valid,
    input  logic       out_a_ready,
    output tl_a_wide_t out_a_bits,
    input  logic       out_d_valid,
    output logic       out_d_ready,
    input  tl_d_wide_t out_d_bits
);

    localparam logic [3:0] BEAT_SHIFT = 4'($clog2(BEAT_BYTES));
    localparam logic [3:0] MAX_OUT    = 4'(MAX_OUTSTANDING);

    logic            rr_q, rr_d, owner_q, owner_d;
    logic [1:0][3:0] outst_q, outst_d;
    logic [1:0]      inc, dec, d_last, d_first, d_busy;
    logic            elig0, elig1, grant, a_valid, a_fire, a_first, a_last, lock;
    logic            dst, d_fire;
    tl_a_t           a_sel;
    tl_d_t           d_strip;
    beats_t          a_beats, d_beats;

    assign elig0 = in0_a_valid && (outst_q[0] < MAX_OUT);
    assign elig1 = in1_a_valid && (outst_q[1] < MAX_OUT);

    // The lock owner bypasses eligibility: its burst was counted on the first beat.
    always_comb begin
        grant   = 1'b0;
        a_valid = 1'b0;
        if (lock) begin
            grant   = owner_q;
            a_valid = owner_q ? in1_a_valid : in0_a_valid;
        end else if (elig0 && elig1) begin
            grant   = rr_q;
            a_valid = 1'b1;
        end else begin
            grant   = elig1;
            a_valid = elig0 || elig1;
        end
    end

    assign a_sel       = grant ? in1_a_bits : in0_a_bits;
    assign a_beats     = num_beats(a_sel.opcode, a_sel.size, 1'b0, BEAT_SHIFT);
    assign out_a_valid = a_valid && !reset;
    assign a_fire      = out_a_valid && out_a_ready;
    assign in0_a_ready = out_a_valid && out_a_ready && !grant;
    assign in1_a_ready = out_a_valid && out_a_ready && grant;
    assign out_a_bits  = {a_sel.opcode, a_sel.param, a_sel.size, grant, a_sel.source,
                          a_sel.address, a_sel.mask, a_sel.data, a_sel.corrupt};

    tl_beat_counter u_a_cnt (
        .clock   (clock),
        .reset   (reset),
        .fire_i  (a_fire),
        .beats_i (a_beats),
        .first_o (a_first),
        .last_o  (a_last),
        .busy_o  (lock)
    );

    assign dst         = out_d_bits.source[1];
    assign d_strip     = {out_d_bits.opcode, out_d_bits.param, out_d_bits.size,
                          out_d_bits.source[0], out_d_bits.sink, out_d_bits.denied,
                          out_d_bits.data, out_d_bits.corrupt};
    assign d_beats     = num_beats(out_d_bits.opcode, out_d_bits.size, 1'b1, BEAT_SHIFT);
    assign in0_d_valid = out_d_valid && !dst && !reset;
    assign in1_d_valid = out_d_valid && dst && !reset;
    assign in0_d_bits  = d_strip;
    assign in1_d_bits  = d_strip;
    assign out_d_ready = !reset && (dst ? in1_d_ready : in0_d_ready);
    assign d_fire      = out_d_valid && out_d_ready;

    tl_beat_counter u_d0_cnt (
        .clock   (clock),
        .reset   (reset),
        .fire_i  (d_fire && !dst),
        .beats_i (d_beats),
        .first_o (d_first[0]),
        .last_o  (d_last[0]),
        .busy_o  (d_busy[0])
    );

    tl_beat_counter u_d1_cnt (
        .clock   (clock),
        .reset   (reset),
        .fire_i  (d_fire && dst),
        .beats_i (d_beats),
        .first_o (d_first[1]),
        .last_o  (d_last[1]),
        .busy_o  (d_busy[1])
    );

    always_comb begin
        outst_d = outst_q;
        inc     = '0;
        dec     = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            inc[c] = a_fire && a_first && (grant == c[0]);
            dec[c] = d_fire && (dst == c[0]) && d_last[c];
            case ({inc[c], dec[c]})
                2'b10:   outst_d[c] = outst_q[c] + 4'd1;
                2'b01:   outst_d[c] = outst_q[c] - 4'd1;
                default: outst_d[c] = outst_q[c];
            endcase
        end
        rr_d    = (a_fire && a_first) ? ~grant : rr_q;
        owner_d = (a_fire && a_first) ? grant : owner_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            outst_q <= '0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            outst_q <= outst_d;
        end
    end

    a_no_underflow0: assert property (@(posedge clock) disable iff (reset) !(dec[0] && outst_q[0] == '0));
    a_no_underflow1: assert property (@(posedge clock) disable iff (reset) !(dec[1] && outst_q[1] == '0));

    logic unused_flags;
    assign unused_flags = ^{a_last, d_first, d_busy};

endmodule

// File: tb/tb_tl_xing_arbiter.sv
// Directed bench for tl_xing_arbiter: a per-cycle scoreboard derived from the
// arbitration rules plus literal checks for each scenario.
module tb_tl_xing_arbiter;
    import tl_xing_pkg::*;

    localparam int MAX = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in0_a_valid = 1'b0, in1_a_valid = 1'b0;
    logic       in0_a_ready, in1_a_ready;
    tl_a_t      in0_a_bits = '0, in1_a_bits = '0;
    logic       in0_d_valid, in1_d_valid;
    logic       in0_d_ready = 1'b0, in1_d_ready = 1'b0;
    tl_d_t      in0_d_bits, in1_d_bits;
    logic       out_a_valid;
    logic       out_a_ready = 1'b1;
    tl_a_wide_t out_a_bits;
    logic       out_d_valid = 1'b0;
    logic       out_d_ready;
    tl_d_wide_t out_d_bits = '0;

    int tests = 0;
    int fails = 0;

    int m_rr, m_lock, m_owner, m_left;
    int m_out[2];
    int m_dleft[2];

    tl_xing_arbiter #(.MAX_OUTSTANDING(4), .BEAT_BYTES(8)) dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_bits(in0_a_bits),
        .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_bits(in0_d_bits),
        .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_bits(in1_a_bits),
        .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_bits(in1_d_bits),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_bits(out_d_bits)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int beats_of(input bit is_d, input int op, input int size);
        bit burst;
        burst = is_d ? (op == 1) : (op <= 1);
        if (!burst || size <= 3) return 1;
        if (size - 3 >= 6) return 64;
        return 2 ** (size - 3);
    endfunction

    // Which client the rules select this cycle and whether a request is offered.
    function automatic void model_grant(output int g, output bit ov);
        bit e0, e1;
        e0 = in0_a_valid && (m_out[0] < MAX);
        e1 = in1_a_valid && (m_out[1] < MAX);
        if (m_lock != 0) begin
            g  = m_owner;
            ov = (g == 1) ? in1_a_valid : in0_a_valid;
        end else begin
            g  = (e0 && e1) ? m_rr : (e1 ? 1 : 0);
            ov = e0 || e1;
        end
    endfunction

    always @(posedge clock) begin
        int g, dst, b;
        bit ov;
        tl_a_t s;
        if (reset) begin
            m_rr = 0; m_lock = 0; m_owner = 0; m_left = 0;
            m_out[0] = 0; m_out[1] = 0; m_dleft[0] = 0; m_dleft[1] = 0;
        end else begin
            model_grant(g, ov);
            dst = out_d_bits.source[1];
            if (ov && out_a_ready) begin
                s = (g == 1) ? in1_a_bits : in0_a_bits;
                if (m_lock != 0) begin
                    m_left--;
                    if (m_left == 0) m_lock = 0;
                end else begin
                    b = beats_of(0, s.opcode, s.size);
                    m_out[g]++;
                    m_rr = 1 - g;
                    if (b > 1) begin m_lock = 1; m_owner = g; m_left = b - 1; end
                end
            end
            if (out_d_valid && ((dst == 1) ? in1_d_ready : in0_d_ready)) begin
                if (m_dleft[dst] == 0) begin
                    b = beats_of(1, out_d_bits.opcode, out_d_bits.size);
                    if (b == 1) m_out[dst]--;
                    else m_dleft[dst] = b - 1;
                end else begin
                    m_dleft[dst]--;
                    if (m_dleft[dst] == 0) m_out[dst]--;
                end
            end
        end
    end

    always @(negedge clock) begin
        int g, dst;
        bit ov, dv;
        tl_a_t s;
        tl_a_wide_t ea;
        tl_d_t ed;
        model_grant(g, ov);
        if (reset) ov = 0;
        chk("out_a_valid", out_a_valid, ov);
        chk("in0_a_ready", in0_a_ready, ov && out_a_ready && g == 0);
        chk("in1_a_ready", in1_a_ready, ov && out_a_ready && g == 1);
        if (ov) begin
            s  = (g == 1) ? in1_a_bits : in0_a_bits;
            ea = '{opcode: s.opcode, param: s.param, size: s.size, source: {g[0], s.source},
                   address: s.address, mask: s.mask, data: s.data, corrupt: s.corrupt};
            chk("out_a_bits", out_a_bits, ea);
        end
        dst = out_d_bits.source[1];
        dv  = !reset && out_d_valid;
        chk("in0_d_valid", in0_d_valid, dv && dst == 0);
        chk("in1_d_valid", in1_d_valid, dv && dst == 1);
        chk("out_d_ready", out_d_ready, !reset && ((dst == 1) ? in1_d_ready : in0_d_ready));
        if (dv) begin
            ed = '{opcode: out_d_bits.opcode, param: out_d_bits.param, size: out_d_bits.size,
                   source: out_d_bits.source[0], sink: out_d_bits.sink, denied: out_d_bits.denied,
                   data: out_d_bits.data, corrupt: out_d_bits.corrupt};
            chk("in_d_bits", (dst == 1) ? in1_d_bits : in0_d_bits, ed);
        end
    end

    function automatic tl_a_t mk_a(input logic [2:0] op, input logic [3:0] size,
                                   input logic src, input logic [31:0] addr);
        tl_a_t a;
        a = '{opcode: op, param: 3'd0, size: size, source: src, address: addr,
              mask: 8'hFF, data: {addr, ~addr}, corrupt: 1'b0};
        return a;
    endfunction

    function automatic tl_d_wide_t mk_d(input logic [2:0] op, input logic [3:0] size,
                                        input logic [1:0] src, input logic [63:0] data);
        tl_d_wide_t d;
        d = '{opcode: op, param: 2'd0, size: size, source: src, sink: 2'd1,
              denied: 1'b0, data: data, corrupt: 1'b0};
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic d_ret(input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            out_d_valid = 1'b1;
            out_d_bits  = mk_d(ACCESS_ACK, 4'd3, {c, 1'b0}, 64'(i));
            in0_d_ready = 1'b1;
            in1_d_ready = 1'b1;
            tick();
        end
        out_d_valid = 1'b0;
        in0_d_ready = 1'b0;
        in1_d_ready = 1'b0;
    endtask

    initial begin
        int fired;
        logic [1:0] exp_src [4];
        exp_src = '{2'b00, 2'b10, 2'b00, 2'b10};

        // Reset with live inputs: every handshake output must stay low.
        in0_a_valid = 1'b1; in1_a_valid = 1'b1;
        in0_a_bits = mk_a(GET, 4'd3, 1'b0, 32'h100);
        in1_a_bits = mk_a(GET, 4'd3, 1'b0, 32'h200);
        out_d_valid = 1'b1; out_d_bits = mk_d(ACCESS_ACK, 4'd3, 2'b00, 64'h1); in0_d_ready = 1'b1;
        tick();
        at_neg();
        chk("rst_out_a_valid", out_a_valid, 1'b0);
        chk("rst_in0_a_ready", in0_a_ready, 1'b0);
        chk("rst_in0_d_valid", in0_d_valid, 1'b0);
        chk("rst_out_d_ready", out_d_ready, 1'b0);
        tick();
        in0_a_valid = 1'b0; in1_a_valid = 1'b0; out_d_valid = 1'b0; in0_d_ready = 1'b0;
        reset = 1'b0;

        // Round-robin between single-beat Gets.
        in0_a_valid = 1'b1; in1_a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("rr_source", out_a_bits.source, exp_src[i]);
            chk("rr_in0_ready", in0_a_ready, (i % 2) == 0);
            tick();
        end
        in0_a_valid = 1'b0; in1_a_valid = 1'b0;
        chk("pin_rr_out0", m_out[0], 2);
        chk("pin_rr_out1", m_out[1], 2);
        d_ret(1'b0, 2);
        d_ret(1'b1, 2);

        // A 4-beat PutFull holds the grant; client 1 waits for the 5th cycle.
        in0_a_bits = mk_a(PUT_FULL, 4'd5, 1'b0, 32'h400);
        in0_a_valid = 1'b1; in1_a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("burst_in0_ready", in0_a_ready, i < 4);
            chk("burst_in1_ready", in1_a_ready, i == 4);
            tick();
            if (i == 3) in0_a_valid = 1'b0;
        end
        in1_a_valid = 1'b0;
        d_ret(1'b0, 1);
        d_ret(1'b1, 1);

        // Outstanding limit on client 1.
        in0_a_bits = mk_a(GET, 4'd3, 1'b0, 32'h500);
        in1_a_valid = 1'b1;
        repeat (4) tick();
        in0_a_valid = 1'b1;
        at_neg();
        chk("lim_in1_ready", in1_a_ready, 1'b0);
        chk("lim_in0_ready", in0_a_ready, 1'b1);
        tick();
        in0_a_valid = 1'b0;
        out_d_valid = 1'b1; out_d_bits = mk_d(ACCESS_ACK_DATA, 4'd3, 2'b10, 64'hAB); in1_d_ready = 1'b1;
        at_neg();
        chk("lim_still_stalled", in1_a_ready, 1'b0);
        tick();
        out_d_valid = 1'b0; in1_d_ready = 1'b0;
        at_neg();
        chk("lim_unblocked", in1_a_ready, 1'b1);
        tick();
        in1_a_valid = 1'b0;
        chk("pin_lim_out1", m_out[1], 4);
        d_ret(1'b1, 4);
        d_ret(1'b0, 1);

        // 8-beat AccessAckData to client 0 with a toggling ready.
        in0_a_bits = mk_a(GET, 4'd6, 1'b1, 32'h600);
        in0_a_valid = 1'b1;
        tick();
        in0_a_valid = 1'b0;
        fired = 0;
        for (int k = 0; k < 40 && fired < 8; k++) begin
            out_d_valid = 1'b1;
            out_d_bits  = mk_d(ACCESS_ACK_DATA, 4'd6, 2'b01, 64'(fired));
            in0_d_ready = k[0];
            at_neg();
            chk("dburst_valid0", in0_d_valid, 1'b1);
            chk("dburst_ready", out_d_ready, in0_d_ready);
            chk("dburst_src", in0_d_bits.source, 1'b1);
            chk("dburst_data", in0_d_bits.data, 64'(fired));
            if (in0_d_ready) fired++;
            tick();
            if (fired == 7 && in0_d_ready) chk("pin_dburst_7", m_out[0], 1);
        end
        out_d_valid = 1'b0; in0_d_ready = 1'b0;
        chk("dburst_beats", fired, 8);
        chk("pin_dburst_8", m_out[0], 0);

        // Simultaneous A first beat and D last beat on client 0.
        in0_a_bits = mk_a(GET, 4'd3, 1'b0, 32'h700);
        in0_a_valid = 1'b1;
        repeat (3) tick();
        out_d_valid = 1'b1; out_d_bits = mk_d(ACCESS_ACK, 4'd3, 2'b00, 64'h0); in0_d_ready = 1'b1;
        tick();
        out_d_valid = 1'b0; in0_d_ready = 1'b0;
        chk("pin_same_cycle", m_out[0], 3);
        at_neg();
        chk("same_fourth_fires", in0_a_ready, 1'b1);
        tick();
        at_neg();
        chk("same_fifth_stalls", in0_a_ready, 1'b0);
        in0_a_valid = 1'b0;
        tick();
        d_ret(1'b0, 4);

        // Reset in the middle of a 4-beat Put.
        in0_a_bits = mk_a(PUT_PARTIAL, 4'd5, 1'b0, 32'h800);
        in0_a_valid = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        in1_a_valid = 1'b1;
        in0_a_bits = mk_a(GET, 4'd3, 1'b0, 32'h900);
        at_neg();
        chk("mid_rst_valid", out_a_valid, 1'b0);
        tick();
        reset = 1'b0;
        at_neg();
        chk("post_rst_in0", in0_a_ready, 1'b1);
        chk("post_rst_src", out_a_bits.source, 2'b00);
        tick();
        at_neg();
        chk("post_rst_next_in1", in1_a_ready, 1'b1);
        tick();
        in0_a_valid = 1'b0; in1_a_valid = 1'b0;
        d_ret(1'b0, 1);
        d_ret(1'b1, 1);
        chk("pin_end_out0", m_out[0], 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
